// File: rtl/dispatch_queue_pkg.sv
// Shared types and constants for the decode -> reservation station dispatch queue.
package dispatch_queue_pkg;

  localparam int DEPTH_DEFAULT  = 8;
  localparam int NUM_RS_DEFAULT = 4;
  localparam int ST_W           = 3;

  // Reservation station codes carried in rs_station
  localparam int RS_NONE   = 0;
  localparam int RS_ALU    = 1;
  localparam int RS_MULDIV = 2;
  localparam int RS_BRANCH = 3;
  localparam int RS_LSU    = 4;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [15:0]     imm;
    logic            is_noop;
    logic [ST_W-1:0] rs_station;
  } decoded_instruction;

  // True when the station code names a real station (1..nrs)
  function automatic logic rs_code_valid(input logic [ST_W-1:0] st, input int nrs);
    return (int'(st) >= 1) && (int'(st) <= nrs);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Handshake bundle between decoder/reservation stations and the dispatch queue.
interface dispatch_queue_if
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int NUM_RS = NUM_RS_DEFAULT
) ();

  logic                     flush;
  logic                     in_valid;
  decoded_instruction       in_instr;
  logic                     in_ready;
  logic [NUM_RS-1:0]        rs_ready;
  logic                     out_valid;
  decoded_instruction       out_instr;
  logic [NUM_RS-1:0]        out_fire;
  logic [$clog2(DEPTH):0]   count;

  // Environment side: decoder, stations and redirect logic
  modport master (
    output flush, in_valid, in_instr, rs_ready,
    input  in_ready, out_valid, out_instr, out_fire, count
  );

  // Queue side
  modport slave (
    input  flush, in_valid, in_instr, rs_ready,
    output in_ready, out_valid, out_instr, out_fire, count
  );

endinterface

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: drops no-ops at the input, issues the head entry to
// its reservation station when that station is ready, flushes on redirect.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int NUM_RS = NUM_RS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  dispatch_queue_if.slave  bus
);

  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  decoded_instruction r_mem [DEPTH];
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  // Kept separately from the pointers so full and empty never alias
  logic [CW-1:0]      r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_store;
  logic               w_issue_ok;
  logic               w_issue;
  logic [NUM_RS-1:0]  w_fire;
  decoded_instruction w_head;

  // Readiness depends on registered occupancy only, never on rs_ready
  assign w_in_ready  = rst_n && (r_count < FULL_COUNT);
  assign w_out_valid = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  // Invalid station codes and no-ops are consumed but never stored
  assign w_store = bus.in_valid && w_in_ready && !bus.flush &&
                   !bus.in_instr.is_noop &&
                   rs_code_valid(bus.in_instr.rs_station, NUM_RS);

  assign w_issue_ok = w_out_valid && !bus.flush;

  // One fire bit per station; only the head's station can match, so at most one is set
  generate
    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_fire
      assign w_fire[gi] = w_issue_ok && bus.rs_ready[gi] &&
                          (w_head.rs_station == ST_W'(gi + 1));
    end
  endgenerate

  assign w_issue = |w_fire;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_head;
  assign bus.out_fire  = w_fire;
  assign bus.count     = r_count;

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  // Pointer and occupancy update; flush empties the queue on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_store, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: vector table plus multi-cycle sequences.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic clk;
  logic rst_n;

  dispatch_queue_if #(.DEPTH(8), .NUM_RS(4)) bus ();

  dispatch_queue #(.DEPTH(8), .NUM_RS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v;
    logic       noop;
    logic [2:0] st;
    logic [7:0] tag;
    logic [3:0] rdy;
    logic       e_in_ready;
    logic       e_valid;
    logic [3:0] e_fire;
    int         e_count;
    logic [7:0] e_tag;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic decoded_instruction mk(input logic noop, input logic [2:0] st,
                                             input logic [7:0] tag);
    decoded_instruction d;
    d            = '0;
    d.opcode     = (int'(st) == RS_LSU) ? OP_LW : OP_ADDIU;
    d.rd         = 5'd3;
    d.rs1        = 5'd1;
    d.imm        = {8'h00, tag};
    d.is_noop    = noop;
    d.rs_station = st;
    return d;
  endfunction

  function automatic vec_t mkv(input logic v, input logic noop, input logic [2:0] st,
                               input logic [7:0] tag, input logic [3:0] rdy,
                               input logic e_rdy, input logic e_val, input logic [3:0] e_fire,
                               input int e_cnt, input logic [7:0] e_tag);
    vec_t r;
    r.v = v; r.noop = noop; r.st = st; r.tag = tag; r.rdy = rdy;
    r.e_in_ready = e_rdy; r.e_valid = e_val; r.e_fire = e_fire;
    r.e_count = e_cnt; r.e_tag = e_tag;
    return r;
  endfunction

  task automatic drive(input logic v, input logic noop, input logic [2:0] st,
                       input logic [7:0] tag, input logic [3:0] rdy, input logic fl);
    bus.in_valid = v;
    bus.in_instr = mk(noop, st, tag);
    bus.rs_ready = rdy;
    bus.flush    = fl;
  endtask

  // Advance to one time unit after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected values observed before the edge of each cycle
    vecs[0]  = mkv(0, 0, 3'd0, 8'h00, 4'b0000, 1, 0, 4'b0000, 0, 8'h00);
    vecs[1]  = mkv(1, 1, 3'd1, 8'h01, 4'b0000, 1, 0, 4'b0000, 0, 8'h00);
    vecs[2]  = mkv(1, 0, 3'd0, 8'h02, 4'b0000, 1, 0, 4'b0000, 0, 8'h00);
    vecs[3]  = mkv(1, 0, 3'd5, 8'h03, 4'b0000, 1, 0, 4'b0000, 0, 8'h00);
    vecs[4]  = mkv(1, 0, 3'd4, 8'h10, 4'b0000, 1, 0, 4'b0000, 0, 8'h00);
    vecs[5]  = mkv(1, 0, 3'd1, 8'h11, 4'b0001, 1, 1, 4'b0000, 1, 8'h10);
    vecs[6]  = mkv(0, 0, 3'd0, 8'h00, 4'b0001, 1, 1, 4'b0000, 2, 8'h10);
    vecs[7]  = mkv(0, 0, 3'd0, 8'h00, 4'b1000, 1, 1, 4'b1000, 2, 8'h10);
    vecs[8]  = mkv(0, 0, 3'd0, 8'h00, 4'b0000, 1, 1, 4'b0000, 1, 8'h11);
    vecs[9]  = mkv(1, 0, 3'd2, 8'h12, 4'b0001, 1, 1, 4'b0001, 1, 8'h11);
    vecs[10] = mkv(0, 0, 3'd0, 8'h00, 4'b0000, 1, 1, 4'b0000, 1, 8'h12);
    vecs[11] = mkv(1, 0, 3'd3, 8'h13, 4'b0000, 1, 1, 4'b0000, 1, 8'h12);
    vecs[12] = mkv(1, 0, 3'd1, 8'h14, 4'b0000, 1, 1, 4'b0000, 2, 8'h12);
    vecs[13] = mkv(1, 0, 3'd4, 8'h15, 4'b0010, 1, 1, 4'b0010, 3, 8'h12);
    vecs[14] = mkv(0, 0, 3'd0, 8'h00, 4'b1111, 1, 1, 4'b0100, 3, 8'h13);
    vecs[15] = mkv(0, 0, 3'd0, 8'h00, 4'b1111, 1, 1, 4'b0001, 2, 8'h14);
    vecs[16] = mkv(0, 0, 3'd0, 8'h00, 4'b1111, 1, 1, 4'b1000, 1, 8'h15);
    vecs[17] = mkv(0, 0, 3'd0, 8'h00, 4'b1111, 1, 0, 4'b0000, 0, 8'h00);

    // Power-up reset
    rst_n = 1'b0;
    drive(0, 0, 3'd0, 8'h00, 4'b0000, 0);
    #2;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_fire", int'(bus.out_fire), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", int'(bus.in_ready), 1);
    tick();

    // Table: no-op drop, ordering, push+pop, drain
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].noop, vecs[i].st, vecs[i].tag, vecs[i].rdy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), int'(bus.in_ready), int'(vecs[i].e_in_ready));
      chk($sformatf("v%0d_out_valid", i), int'(bus.out_valid), int'(vecs[i].e_valid));
      chk($sformatf("v%0d_out_fire", i), int'(bus.out_fire), int'(vecs[i].e_fire));
      chk($sformatf("v%0d_count", i), int'(bus.count), vecs[i].e_count);
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_head_tag", i), int'(bus.out_instr.imm[7:0]), int'(vecs[i].e_tag));
      $display("vec %0d: in_valid=%0b st=%0d rs_ready=%b -> count=%0d fire=%b",
               i, vecs[i].v, vecs[i].st, vecs[i].rdy, bus.count, bus.out_fire);
      tick();
    end

    // Fill with stations blocked; write pointer wraps past the end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 3'd1, 8'(8'h20 + i), 4'b0000, 0);
      @(negedge clk);
      chk($sformatf("fill%0d_in_ready", i), int'(bus.in_ready), 1);
      tick();
      $display("fill %0d: count=%0d", i, bus.count);
    end
    drive(1, 0, 3'd1, 8'h2F, 4'b0000, 0);
    @(negedge clk);
    chk("full_in_ready", int'(bus.in_ready), 0);
    chk("full_count", int'(bus.count), 8);
    chk("full_head_tag", int'(bus.out_instr.imm[7:0]), 8'h20);
    tick();
    chk("ninth_push_count", int'(bus.count), 8);
    $display("ninth push: count=%0d", bus.count);

    // Push and pop together while full: only the pop happens
    drive(1, 0, 3'd1, 8'h30, 4'b0001, 0);
    @(negedge clk);
    chk("fullpop_fire", int'(bus.out_fire), 4'b0001);
    chk("fullpop_in_ready", int'(bus.in_ready), 0);
    tick();
    chk("fullpop_count", int'(bus.count), 7);
    chk("fullpop_head_tag", int'(bus.out_instr.imm[7:0]), 8'h21);
    $display("full push+pop: count=%0d", bus.count);

    drive(0, 0, 3'd0, 8'h00, 4'b0001, 0);
    tick();
    chk("pop_to6_count", int'(bus.count), 6);
    chk("pop_to6_head_tag", int'(bus.out_instr.imm[7:0]), 8'h22);

    // Flush with a ready head and an incoming entry
    drive(1, 0, 3'd1, 8'h31, 4'b0001, 1);
    @(negedge clk);
    chk("flush_fire", int'(bus.out_fire), 0);
    tick();
    chk("flush_count", int'(bus.count), 0);
    chk("flush_out_valid", int'(bus.out_valid), 0);
    $display("flush: count=%0d", bus.count);
    @(negedge clk);
    chk("flush2_fire", int'(bus.out_fire), 0);
    tick();
    chk("flush2_count", int'(bus.count), 0);

    // Refill after flush
    drive(1, 0, 3'd2, 8'h40, 4'b0000, 0);
    tick();
    chk("postflush_count", int'(bus.count), 1);
    chk("postflush_head_tag", int'(bus.out_instr.imm[7:0]), 8'h40);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 3'd2, 8'(8'h40 + i), 4'b0000, 0);
      tick();
    end
    drive(0, 0, 3'd0, 8'h00, 4'b1111, 0);
    chk("prereset_count", int'(bus.count), 5);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_in_ready", int'(bus.in_ready), 0);
    chk("async_rst_fire", int'(bus.out_fire), 0);
    tick();
    chk("held_rst_count", int'(bus.count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_rst_in_ready", int'(bus.in_ready), 1);
    chk("after_rst_out_valid", int'(bus.out_valid), 0);
    $display("mid-stream reset: count=%0d in_ready=%0b", bus.count, bus.in_ready);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
